// File: rtl/pmem_line_arbiter_if.sv
// Bundle of I-side, D-side and pmem-side signals around pmem_line_arbiter.
// master: the arbiter. slave: the caches plus the memory model (or a bench).
interface pmem_line_arbiter_if #(
   parameter int unsigned width = 256
);
   logic             i_read;
   logic [31:0]      i_address;
   logic [width-1:0] i_rdata;
   logic             i_resp;

   logic             d_read;
   logic             d_write;
   logic [31:0]      d_address;
   logic [width-1:0] d_wdata;
   logic [width-1:0] d_rdata;
   logic             d_resp;

   logic             pmem_read;
   logic             pmem_write;
   logic [31:0]      pmem_address;
   logic [width-1:0] pmem_wdata;
   logic [width-1:0] pmem_rdata;
   logic             pmem_resp;

   modport master (
      input  i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport slave (
      output i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/pmem_line_arbiter.sv
// pmem_line_arbiter: shares one cache-line pmem port between the I-cache miss
// path and the D-cache/victim path. One transaction at a time:
// IDLE -> BUSY_x -> RESP_x -> IDLE.
// Build option PMEM_ARB_ROUND_ROBIN_EN: when both sides request, the side
// opposite the last grant wins. Without it, D has fixed priority and a
// saturating starvation counter forces an I grant after STARVE_LIMIT D grants
// taken while I waits.
module pmem_line_arbiter #(
   parameter int unsigned width        = 256,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   pmem_line_arbiter_if.master bus
);

   typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_e;

   state_e           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [width-1:0] wdata_q, wdata_d;
   logic [width-1:0] i_rdata_q, i_rdata_d;
   logic [width-1:0] d_rdata_q, d_rdata_d;
   logic             pmem_read_q, pmem_read_d;
   logic             pmem_write_q, pmem_write_d;
   logic             i_resp_q, i_resp_d;
   logic             d_resp_q, d_resp_d;
   logic             i_req, d_req, grant_i;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
   logic             last_grant_q, last_grant_d;   // 1: last grant went to I
`else
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   logic [3:0]       starve_q, starve_d;
`endif

   // Arbitration and next-state/output computation for the transaction FSM.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      pmem_read_d  = pmem_read_q;
      pmem_write_d = pmem_write_q;
      i_resp_d     = 1'b0;
      d_resp_d     = 1'b0;
      i_req        = bus.i_read;
      d_req        = bus.d_read | bus.d_write;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
      grant_i      = i_req && (!d_req || !last_grant_q);
`else
      starve_d     = starve_q;
      grant_i      = i_req && (!d_req || (starve_q == STARVE_MAX));
`endif

      case (state_q)
         IDLE: begin
            if (grant_i) begin
               state_d      = BUSY_I;
               addr_d       = bus.i_address;
               pmem_read_d  = 1'b1;
               pmem_write_d = 1'b0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
               last_grant_d = 1'b1;
`else
               starve_d     = '0;
`endif
            end else if (d_req) begin
               // A write wins over a simultaneous read; the read is dropped.
               state_d      = BUSY_D;
               addr_d       = bus.d_address;
               wdata_d      = bus.d_wdata;
               pmem_write_d = bus.d_write;
               pmem_read_d  = ~bus.d_write;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
               last_grant_d = 1'b0;
`else
               if (bus.i_read && (starve_q != STARVE_MAX))
                  starve_d = starve_q + 4'd1;
`endif
            end
         end
         BUSY_I: begin
            if (bus.pmem_resp) begin
               state_d      = RESP_I;
               pmem_read_d  = 1'b0;
               pmem_write_d = 1'b0;
               i_rdata_d    = bus.pmem_rdata;
               i_resp_d     = 1'b1;
            end
         end
         BUSY_D: begin
            if (bus.pmem_resp) begin
               state_d      = RESP_D;
               pmem_read_d  = 1'b0;
               pmem_write_d = 1'b0;
               if (!pmem_write_q)
                  d_rdata_d = bus.pmem_rdata;
               d_resp_d     = 1'b1;
            end
         end
         RESP_I, RESP_D: state_d = IDLE;
         default:        state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any in-flight access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
         i_resp_q     <= 1'b0;
         d_resp_q     <= 1'b0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
         last_grant_q <= 1'b0;
`else
         starve_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         pmem_read_q  <= pmem_read_d;
         pmem_write_q <= pmem_write_d;
         i_resp_q     <= i_resp_d;
         d_resp_q     <= d_resp_d;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`else
         starve_q     <= starve_d;
`endif
      end
   end

   assign bus.pmem_read    = pmem_read_q;
   assign bus.pmem_write   = pmem_write_q;
   assign bus.pmem_address = addr_q;
   assign bus.pmem_wdata   = wdata_q;
   assign bus.i_rdata      = i_rdata_q;
   assign bus.i_resp       = i_resp_q;
   assign bus.d_rdata      = d_rdata_q;
   assign bus.d_resp       = d_resp_q;

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Bench for pmem_line_arbiter: directed scenarios followed by randomized
// request mixes, checked against a transaction-level reference model.
module tb_pmem_line_arbiter;
   localparam int unsigned W     = 256;
   localparam int unsigned LIMIT = 4;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   // reference model state
   bit          i_pend, d_rd, d_wr;
   logic [31:0] i_addr_m, d_addr_m;
   logic [W-1:0] d_wdata_m, exp_i_rdata, exp_d_rdata;
   int          starve;
   bit          last_i;

   pmem_line_arbiter_if #(.width(W)) bus ();

   pmem_line_arbiter #(.width(W), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rand_line();
      logic [W-1:0] r;
      for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic apply_reqs();
      bus.i_read    = i_pend;
      bus.i_address = i_addr_m;
      bus.d_read    = d_rd;
      bus.d_write   = d_wr;
      bus.d_address = d_addr_m;
      bus.d_wdata   = d_wdata_m;
   endtask

   // One complete transaction, entered and left in an IDLE cycle.
   task automatic do_round(input int unsigned delay, input bit drop_mid,
                           input bit stale, input logic [W-1:0] rd);
      bit          win_i, wr;
      logic [31:0] a;
      logic [W-1:0] wd;
      if (!(d_rd || d_wr))  win_i = 1'b1;
      else if (!i_pend)     win_i = 1'b0;
      else begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
         win_i = !last_i;
`else
         win_i = (starve >= int'(LIMIT));
`endif
      end
      wr = !win_i && d_wr;
      a  = win_i ? i_addr_m : d_addr_m;
      wd = d_wdata_m;
      if (win_i) starve = 0;
      else if (i_pend && starve < int'(LIMIT)) starve++;
      last_i = win_i;

      apply_reqs();
      tick();
      check("grant_read", bus.pmem_read, !wr);
      check("grant_write", bus.pmem_write, wr);
      check("grant_addr", bus.pmem_address, a);
      if (wr) check("grant_wdata", bus.pmem_wdata, wd);

      if (win_i) i_pend = 1'b0;
      else begin d_rd = 1'b0; d_wr = 1'b0; end
      if (drop_mid) apply_reqs();

      for (int unsigned k = 0; k < delay; k++) begin
         tick();
         check("busy_strobe", {bus.pmem_read, bus.pmem_write}, {!wr, wr});
         check("busy_resp", {bus.i_resp, bus.d_resp}, 2'b00);
      end

      bus.pmem_rdata = rd;
      bus.pmem_resp  = 1'b1;
      tick();
      bus.pmem_resp  = 1'b0;
      if (!wr) begin
         if (win_i) exp_i_rdata = rd;
         else       exp_d_rdata = rd;
      end
      check("resp_i", bus.i_resp, win_i);
      check("resp_d", bus.d_resp, !win_i);
      check("resp_i_rdata", bus.i_rdata, exp_i_rdata);
      check("resp_d_rdata", bus.d_rdata, exp_d_rdata);
      check("resp_strobe", {bus.pmem_read, bus.pmem_write}, 2'b00);

      // stale: winner keeps its request high through the response cycle
      if (!stale) apply_reqs();
      bus.pmem_rdata = rand_line();
      bus.pmem_resp  = 1'($urandom_range(0, 1));
      tick();
      bus.pmem_resp  = 1'b0;
      apply_reqs();
      check("idle_resp", {bus.i_resp, bus.d_resp}, 2'b00);
      check("idle_strobe", {bus.pmem_read, bus.pmem_write}, 2'b00);
      check("idle_i_rdata", bus.i_rdata, exp_i_rdata);
      check("idle_d_rdata", bus.d_rdata, exp_d_rdata);
   endtask

   initial begin
      logic [W-1:0] pat;
      vectors = 0;
      miscompares = 0;
      i_pend = 0; d_rd = 0; d_wr = 0;
      i_addr_m = '0; d_addr_m = '0; d_wdata_m = '0;
      exp_i_rdata = '0; exp_d_rdata = '0;
      starve = 0; last_i = 0;
      bus.pmem_rdata = '0;
      bus.pmem_resp  = 1'b0;
      apply_reqs();

      // reset
      rst = 1'b0;
      tick();
      tick();
      check("rst_pmem_read", bus.pmem_read, 1'b0);
      check("rst_pmem_write", bus.pmem_write, 1'b0);
      check("rst_pmem_address", bus.pmem_address, '0);
      check("rst_pmem_wdata", bus.pmem_wdata, '0);
      check("rst_i_rdata", bus.i_rdata, '0);
      check("rst_i_resp", bus.i_resp, 1'b0);
      check("rst_d_rdata", bus.d_rdata, '0);
      check("rst_d_resp", bus.d_resp, 1'b0);
      rst = 1'b1;
      tick();

      // single I fill at 0x1000, memory answers at cycle 5
      pat = {8{32'hA5A5_0001}};
      i_pend = 1; i_addr_m = 32'h0000_1000;
      do_round(4, 0, 0, pat);

      // D write-back at 0x2000
      pat = {8{32'hB0B0_0002}};
      d_wr = 1; d_addr_m = 32'h0000_2000; d_wdata_m = pat;
      do_round(2, 0, 0, rand_line());

      // I and D fills rise together
      i_pend = 1; i_addr_m = 32'h0000_3000;
      d_rd = 1; d_addr_m = 32'h0000_5000;
      do_round(0, 0, 1, rand_line());
      do_round(1, 0, 0, rand_line());

      // I held while D re-requests back to back
      i_pend = 1; i_addr_m = 32'h0000_3040;
      for (int k = 0; k < int'(LIMIT) + 1; k++) begin
         d_rd = 1; d_addr_m = 32'h0000_4000 + 32'(k * 64);
         do_round(0, 0, 0, rand_line());
      end
      d_rd = 1; d_addr_m = 32'h0000_4800;
      do_round(0, 0, 0, rand_line());
      if (i_pend) do_round(0, 0, 0, rand_line());

      // both d_read and d_write: write serviced, read dropped
      d_rd = 1; d_wr = 1; d_addr_m = 32'h0000_6000; d_wdata_m = rand_line();
      do_round(1, 0, 0, rand_line());

      // reset during a D write-back
      d_wr = 1; d_addr_m = 32'h0000_7000; d_wdata_m = rand_line();
      apply_reqs();
      tick();
      check("pre_rst_write", bus.pmem_write, 1'b1);
      rst = 1'b0;
      #1;
      check("async_rst_write", bus.pmem_write, 1'b0);
      d_wr = 0; starve = 0; last_i = 0;
      exp_i_rdata = '0; exp_d_rdata = '0;
      apply_reqs();
      tick();
      rst = 1'b1;
      bus.pmem_rdata = rand_line();
      bus.pmem_resp  = 1'b1;
      tick();
      bus.pmem_resp  = 1'b0;
      check("late_resp_d_resp", bus.d_resp, 1'b0);
      check("late_resp_d_rdata", bus.d_rdata, '0);
      tick();
      check("late_resp_idle", {bus.d_resp, bus.pmem_write, bus.pmem_read}, 3'b000);
      d_rd = 1; d_addr_m = 32'h0000_7040;
      do_round(1, 0, 0, rand_line());

      // randomized request mixes
      for (int n = 0; n < 80; n++) begin
         if (!i_pend && $urandom_range(0, 1) == 1) begin
            i_pend = 1; i_addr_m = $urandom & 32'hFFFF_FFE0;
         end
         if (!(d_rd || d_wr) && $urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 3))
               0, 1:    begin d_rd = 1; d_wr = 0; end
               2:       begin d_rd = 0; d_wr = 1; end
               default: begin d_rd = 1; d_wr = 1; end
            endcase
            d_addr_m  = $urandom & 32'hFFFF_FFE0;
            d_wdata_m = rand_line();
         end
         if (!i_pend && !(d_rd || d_wr)) begin
            i_pend = 1; i_addr_m = $urandom & 32'hFFFF_FFE0;
         end
         do_round($urandom_range(0, 3), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, rand_line());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
